// File: rtl/oled_frame_sequencer_if.sv
// Command/byte link between the OLED frame sequencer and the I2C master.
// The sequencer is the master side: it drives the command and the byte stream.
// The I2C master is the slave side: it drives the ready lines and missed_ack.
interface oled_frame_sequencer_if;
  logic [6:0] cmd_address;
  logic       cmd_start;
  logic       cmd_write_multiple;
  logic       cmd_stop;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;
  logic       missed_ack;

  modport master (
    output cmd_address, cmd_start, cmd_write_multiple, cmd_stop, cmd_valid,
    output tx_data, tx_valid, tx_last,
    input  cmd_ready, tx_ready, missed_ack
  );

  modport slave (
    input  cmd_address, cmd_start, cmd_write_multiple, cmd_stop, cmd_valid,
    input  tx_data, tx_valid, tx_last,
    output cmd_ready, tx_ready, missed_ack
  );
endinterface

// File: rtl/oled_frame_sequencer.sv
// OLED frame sequencer: feeds the SSD1306 I2C master with an init sequence
// (first draw only), a column/page addressing sequence and a 1024-byte glyph
// frame fetched from an external glyph ROM, one write-multiple transaction each.
// Optional build macro: OLED_SEQ_INVERT_EN (inverse video on ROM bytes only).
//
// Handshakes: a command or byte transfers on a rising clk edge where its valid
// and the matching ready are both 1. Once valid is raised, valid, data and last
// stay unchanged until that edge. missed_ack outranks a same-edge transfer.
module oled_frame_sequencer #(
  parameter logic [6:0] I2C_ADDR   = 7'h3C,
  parameter int         GSEL_W     = 5,
  parameter int         GAP_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                draw_req,
  input  logic [GSEL_W-1:0]   glyph_sel,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [GSEL_W+9:0]   rom_addr,
  input  logic [7:0]          rom_data,
  output logic [2:0]          fsm_state,
  oled_frame_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_BYTE, S_FETCH, S_WAIT, S_SEND, S_GAP, S_FIN
  } state_t;

  typedef enum logic [1:0] {PH_INIT, PH_ADDR, PH_DATA} phase_t;

`ifdef OLED_SEQ_INVERT_EN
  localparam logic [7:0] ROM_MASK = 8'hFF;
`else
  localparam logic [7:0] ROM_MASK = 8'h00;
`endif

  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

  state_t              state;
  phase_t              phase;
  logic                init_done;
  logic                cmd_valid;
  logic [GSEL_W-1:0]   glyph;
  logic [4:0]          idx;
  logic [4:0]          idx_n;
  logic [9:0]          rom_cnt;
  logic [9:0]          rom_cnt_n;
  logic [31:0]         gap_cnt;

  assign idx_n     = idx + 5'd1;
  assign rom_cnt_n = rom_cnt + 10'd1;
  assign fsm_state = state;

  // The four command lines are just cmd_valid; the address is shown only then.
  assign bus.cmd_valid          = cmd_valid;
  assign bus.cmd_start          = cmd_valid;
  assign bus.cmd_write_multiple = cmd_valid;
  assign bus.cmd_stop           = cmd_valid;
  assign bus.cmd_address        = cmd_valid ? I2C_ADDR : 7'd0;

  // Table bytes: INIT (27 bytes), ADDR (7 bytes), and the lone 0x40 data
  // control byte that opens the ROM transaction.
  function automatic logic [7:0] table_byte(input phase_t ph, input logic [4:0] i);
    logic [7:0] b;
    b = 8'h40;
    if (ph == PH_INIT) begin
      case (i)
        5'd0:  b = 8'h00; 5'd1:  b = 8'hAE; 5'd2:  b = 8'hD5; 5'd3:  b = 8'h80;
        5'd4:  b = 8'hA8; 5'd5:  b = 8'h3F; 5'd6:  b = 8'hD3; 5'd7:  b = 8'h00;
        5'd8:  b = 8'h40; 5'd9:  b = 8'h8D; 5'd10: b = 8'h14; 5'd11: b = 8'h20;
        5'd12: b = 8'h00; 5'd13: b = 8'hA1; 5'd14: b = 8'hC8; 5'd15: b = 8'hDA;
        5'd16: b = 8'h12; 5'd17: b = 8'h81; 5'd18: b = 8'hCF; 5'd19: b = 8'hD9;
        5'd20: b = 8'hF1; 5'd21: b = 8'hD8; 5'd22: b = 8'h40; 5'd23: b = 8'hA4;
        5'd24: b = 8'hA6; 5'd25: b = 8'h2E; default: b = 8'hAF;
      endcase
    end else if (ph == PH_ADDR) begin
      case (i)
        5'd0: b = 8'h00; 5'd1: b = 8'h21; 5'd2: b = 8'h00; 5'd3: b = 8'h7F;
        5'd4: b = 8'h22; 5'd5: b = 8'h00; default: b = 8'h07;
      endcase
    end
    return b;
  endfunction

  // Index of the final table byte of a table-only transaction.
  function automatic logic [4:0] last_idx(input phase_t ph);
    return (ph == PH_INIT) ? 5'd26 : 5'd6;
  endfunction

  // Sequencer FSM with registered outputs; abort on missed_ack beats everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      phase        <= PH_INIT;
      init_done    <= 1'b0;
      cmd_valid    <= 1'b0;
      glyph        <= '0;
      idx          <= '0;
      rom_cnt      <= '0;
      gap_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      rom_addr     <= '0;
      bus.tx_data  <= '0;
      bus.tx_valid <= 1'b0;
      bus.tx_last  <= 1'b0;
    end else if (state != S_IDLE && bus.missed_ack) begin
      state        <= S_IDLE;
      init_done    <= 1'b0;
      cmd_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b1;
      bus.tx_data  <= '0;
      bus.tx_valid <= 1'b0;
      bus.tx_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (draw_req) begin
            glyph     <= glyph_sel;
            busy      <= 1'b1;
            phase     <= init_done ? PH_ADDR : PH_INIT;
            cmd_valid <= 1'b1;
            state     <= S_CMD;
          end
        end
        S_CMD: begin
          if (bus.cmd_ready) begin
            cmd_valid    <= 1'b0;
            idx          <= '0;
            bus.tx_data  <= table_byte(phase, 5'd0);
            bus.tx_valid <= 1'b1;
            bus.tx_last  <= 1'b0;
            state        <= S_BYTE;
          end
        end
        S_BYTE: begin
          if (bus.tx_ready) begin
            if (phase == PH_DATA) begin
              bus.tx_valid <= 1'b0;
              rom_cnt      <= '0;
              rom_addr     <= {glyph, 10'd0};
              state        <= S_FETCH;
            end else if (bus.tx_last) begin
              bus.tx_valid <= 1'b0;
              bus.tx_last  <= 1'b0;
              if (phase == PH_INIT) init_done <= 1'b1;
              gap_cnt      <= '0;
              state        <= S_GAP;
            end else begin
              idx         <= idx_n;
              bus.tx_data <= table_byte(phase, idx_n);
              bus.tx_last <= (idx_n == last_idx(phase));
            end
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          bus.tx_data  <= rom_data ^ ROM_MASK;
          bus.tx_valid <= 1'b1;
          bus.tx_last  <= (rom_cnt == 10'd1023);
          state        <= S_SEND;
        end
        S_SEND: begin
          if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            if (bus.tx_last) begin
              bus.tx_last <= 1'b0;
              gap_cnt     <= '0;
              state       <= S_GAP;
            end else begin
              rom_cnt  <= rom_cnt_n;
              rom_addr <= {glyph, rom_cnt_n};
              state    <= S_FETCH;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (phase == PH_DATA) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FIN;
            end else begin
              phase     <= (phase == PH_INIT) ? PH_ADDR : PH_DATA;
              cmd_valid <= 1'b1;
              state     <= S_CMD;
            end
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Bench for oled_frame_sequencer: random glyph ROM, expected byte stream built
// from the transaction tables and frame layout, negedge monitor + scoreboard.
module tb_oled_frame_sequencer;
  localparam int GAP = 4;

  localparam logic [7:0] INIT_TBL [0:26] = '{
    8'h00, 8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
    8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9,
    8'hF1, 8'hD8, 8'h40, 8'hA4, 8'hA6, 8'h2E, 8'hAF};
  localparam logic [7:0] ADDR_TBL [0:6] = '{
    8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

`ifdef OLED_SEQ_INVERT_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        draw_req = 1'b0;
  logic [4:0]  glyph_sel = '0;
  logic        busy, done, err;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic [2:0]  fsm_state;

  oled_frame_sequencer_if bus();

  oled_frame_sequencer #(.I2C_ADDR(7'h3C), .GSEL_W(5), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .draw_req(draw_req), .glyph_sel(glyph_sel),
    .busy(busy), .done(done), .err(err), .rom_addr(rom_addr),
    .rom_data(rom_data), .fsm_state(fsm_state), .bus(bus.master)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // glyph ROM: data valid one cycle after the address
  logic [7:0] rom [0:32767];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // scoreboard: {is_rom, rom address, last, data}
  logic [24:0] exp_q[$];
  logic [24:0] e;
  int  n_checks = 0, n_errors = 0;
  int  bytes_seen, rom_seen, cmd_seen, done_seen, exp_bytes, exp_cmds;
  bit  model_init = 0;
  bit  bp = 0;
  bit  stall_prev = 0, in_gap = 0;
  int  gap_len;
  logic [8:0] hold_word;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the byte stream one draw must produce.
  task automatic model_draw(input logic [4:0] g);
    int a;
    bytes_seen = 0; rom_seen = 0; cmd_seen = 0; done_seen = 0;
    exp_bytes = 0; exp_cmds = 0; in_gap = 0;
    if (!model_init) begin
      for (int i = 0; i < 27; i++) exp_q.push_back({1'b0, 15'd0, (i == 26), INIT_TBL[i]});
      exp_bytes += 27; exp_cmds += 1;
    end
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 15'd0, (i == 6), ADDR_TBL[i]});
    exp_q.push_back({1'b0, 15'd0, 1'b0, 8'h40});
    for (int k = 0; k < 1024; k++) begin
      a = int'(g) * 1024 + (k / 128) * 128 + (k % 128);
      exp_q.push_back({1'b1, a[14:0], (k == 1023), rom[a] ^ INV});
    end
    exp_bytes += 1032; exp_cmds += 2;
    model_init = 1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_flags"}, {busy, done, err, bus.cmd_valid, bus.cmd_start,
              bus.cmd_write_multiple, bus.cmd_stop, bus.tx_valid, bus.tx_last}, 0);
    check_eq({tag, "_cmd_addr"}, bus.cmd_address, 0);
    check_eq({tag, "_tx_data"}, bus.tx_data, 0);
    check_eq({tag, "_rom_addr"}, rom_addr, 0);
  endtask

  // monitor: sample away from the active edge
  always @(negedge clk) begin
    if (!rst || bus.missed_ack) begin
      stall_prev = 0;
      in_gap = 0;
    end else begin
      if (done) done_seen++;
      if (in_gap) begin
        if (bus.cmd_valid || done) begin
          check_eq("gap_len", gap_len, GAP);
          in_gap = 0;
        end else if (!bus.tx_valid) gap_len++;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        cmd_seen++;
        check_eq("cmd_address", bus.cmd_address, 7'h3C);
        check_eq("cmd_flags", {bus.cmd_start, bus.cmd_write_multiple, bus.cmd_stop}, 3'b111);
      end
      if (stall_prev) begin
        check_eq("hold_valid", bus.tx_valid, 1);
        check_eq("hold_data", {bus.tx_last, bus.tx_data}, hold_word);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        bytes_seen++;
        check_eq("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("tx_data", bus.tx_data, e[7:0]);
          check_eq("tx_last", bus.tx_last, e[8]);
          if (e[24]) begin
            check_eq("rom_addr", rom_addr, e[23:9]);
            rom_seen++;
          end
          if (bus.tx_last) begin
            in_gap = 1;
            gap_len = 0;
          end
        end
      end
      stall_prev = bus.tx_valid && !bus.tx_ready;
      hold_word = {bus.tx_last, bus.tx_data};
    end
  end

  // driver: ready lines, random when backpressure is on
  initial begin
    bus.cmd_ready = 1'b1;
    bus.tx_ready = 1'b1;
    bus.missed_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bp) begin
        bus.tx_ready = 1'($urandom_range(0, 1));
        bus.cmd_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.tx_ready = 1'b1;
        bus.cmd_ready = 1'b1;
      end
    end
  end

  task automatic start_draw(input logic [4:0] g);
    @(posedge clk); #1;
    draw_req = 1'b1; glyph_sel = g;
    @(posedge clk); #1;
    draw_req = 1'b0;
    check_eq("busy_on_accept", busy, 1);
  endtask

  task automatic run_draw(input logic [4:0] g, input bit bp_on);
    int cycles;
    model_draw(g);
    bp = bp_on;
    start_draw(g);
    cycles = 0;
    while (!done && cycles < 20000) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 200) begin draw_req = 1'b1; glyph_sel = 5'($urandom); end
      if (cycles == 201) draw_req = 1'b0;
    end
    draw_req = 1'b0;
    check_eq("done_seen", done, 1);
    check_eq("busy_in_fin", busy, 0);
    draw_req = 1'b1; glyph_sel = 5'($urandom);
    @(posedge clk); #1;
    draw_req = 1'b0;
    bp = 0;
    check_eq("done_one_cycle", done, 0);
    check_eq("busy_after", busy, 0);
    check_eq("queue_empty", exp_q.size(), 0);
    check_eq("byte_count", bytes_seen, exp_bytes);
    check_eq("cmd_count", cmd_seen, exp_cmds);
    check_eq("done_count", done_seen, 1);
    @(posedge clk); #1;
    check_eq("req_at_done_ignored", busy, 0);
    exp_q.delete();
  endtask

  task automatic wait_rom_byte(input int n, input string tag);
    int cycles;
    cycles = 0;
    while (!(rom_seen == n && bus.tx_valid) && cycles < 10000) begin
      @(posedge clk); #1;
      cycles++;
    end
    check_eq(tag, rom_seen, n);
  endtask

  task automatic run_abort_ack(input logic [4:0] g);
    model_draw(g);
    bp = 0;
    start_draw(g);
    wait_rom_byte(100, "reach_byte100");
    bus.missed_ack = 1'b1;
    @(posedge clk); #1;
    bus.missed_ack = 1'b0;
    check_eq("err_pulse", err, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_valids", {bus.tx_valid, bus.cmd_valid}, 0);
    exp_q.delete();
    model_init = 0;
    @(posedge clk); #1;
    check_eq("err_one_cycle", err, 0);
    check_eq("abort_idle_busy", busy, 0);
  endtask

  task automatic run_mid_reset(input logic [4:0] g);
    model_draw(g);
    bp = 0;
    start_draw(g);
    wait_rom_byte(50, "reach_byte50");
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midrst");
    rst = 1'b1;
    exp_q.delete();
    model_init = 0;
    @(posedge clk); #1;
    check_eq("midrst_no_pulse", {done, err}, 0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h0F;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    run_draw(5'd0, 1'b0);
    run_draw(5'd3, 1'b0);
    run_abort_ack(5'($urandom));
    run_draw(5'($urandom), 1'b1);
    run_mid_reset(5'($urandom));
    run_draw(5'($urandom), 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
